// File: rtl/ps2_lr_decoder.sv
// ps2_lr_decoder
//   Receives PS/2 keyboard frames and turns the extended Left/Right arrow
//   make/break sequences into level outputs for the ball-position logic.
//
//   Optional feature: define PS2_PARITY_CHECK_EN to reject frames whose
//   parity bit fails the odd-parity rule (frame_err, byte discarded).
//   Undefined, the parity bit is clocked past but ignored.
//
// Parameters
//   TIMEOUT_CYCLES : clkdiv cycles allowed between PS/2 falling edges in a frame
//
// Ports
//   clkdiv     in   system clock, all state on its rising edge
//   reset      in   asynchronous, active-high reset
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_data   in   raw keyboard data (asynchronous)
//   left       out  high while Left-arrow is held
//   right      out  high while Right-arrow is held
//   byte_valid out  one-cycle pulse per accepted byte
//   scan_code  out  last accepted byte
//   frame_err  out  one-cycle pulse on a rejected frame
module ps2_lr_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clkdiv,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left,
    output logic       right,
    output logic       byte_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_next;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          din;

    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          parity_ok;
    logic          accept;
    logic          reject;

    logic          ext;
    logic          brk;

`ifdef PS2_PARITY_CHECK_EN
    logic          parity_bit;
`endif

    // ------------------------------------------------------------------
    // Synchronizers and falling-edge detect (idle level of the bus is 1)
    // ------------------------------------------------------------------
    always_ff @(posedge clkdiv or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];
    assign din  = data_sync[1];

    // Timeout fires once TIMEOUT_CYCLES edges have elapsed since the last
    // falling edge while a frame is in progress.
    assign timeout = (state != IDLE) && !fall && (tcnt == T_LAST);

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data bits XOR parity bit must be 1.
    assign parity_ok = ^{shift, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clkdiv or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!din) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: outputs (strobes registered below)
    // ------------------------------------------------------------------
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (timeout) begin
            reject = 1'b1;
        end else if (state == STOP && fall) begin
            if (din && parity_ok) begin
                accept = 1'b1;
            end else begin
                reject = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame datapath: shift register, bit counter, timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clkdiv or posedge reset) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            tcnt    <= '0;
        end else begin
            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else if (tcnt != T_LAST) begin
                tcnt <= tcnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shift   <= {din, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clkdiv or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (state == PARITY && fall) begin
            parity_bit <= din;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Byte layer: prefix flags and arrow levels.  Levels move only on the
    // edge that raises byte_valid, so they are glitch-free under typematic
    // repeat (a repeated make rewrites the same value).
    // ------------------------------------------------------------------
    always_ff @(posedge clkdiv or posedge reset) begin
        if (reset) begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            left       <= 1'b0;
            right      <= 1'b0;
        end else begin
            byte_valid <= accept;
            frame_err  <= reject;
            if (accept) begin
                scan_code <= shift;
                if (shift == CODE_EXT) begin
                    ext <= 1'b1;
                end else if (shift == CODE_BRK) begin
                    brk <= 1'b1;
                end else begin
                    if (ext) begin
                        if (shift == CODE_LEFT) begin
                            left <= ~brk;
                        end else if (shift == CODE_RIGHT) begin
                            right <= ~brk;
                        end
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_lr_decoder.sv
// tb_ps2_lr_decoder
//   Directed PS/2 frames with hand-computed expected levels.  Stimulus
//   pushes each expected event into a queue; a monitor pops and compares
//   whenever the DUT pulses byte_valid or frame_err.
module tb_ps2_lr_decoder;

    localparam int unsigned TMO  = 100;
    localparam int unsigned HALF = 8;

    logic       clkdiv;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       left;
    logic       right;
    logic       byte_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         l;
        bit         r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ps2_lr_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clkdiv    (clkdiv),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .left      (left),
        .right     (right),
        .byte_valid(byte_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    initial clkdiv = 1'b0;
    always #5 clkdiv = ~clkdiv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_byte(input logic [7:0] code, input bit l, input bit r);
        exp_t e;
        e.err = 1'b0; e.code = code; e.l = l; e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.err = 1'b1; e.code = 8'h00; e.l = 1'b0; e.r = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(posedge clkdiv);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clkdiv);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit bad_par);
        logic par;
        par = bad_par ? ^b : ~^b;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clkdiv);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit l, input bit r);
        expect_byte(b, l, r);
        send_frame(b, 1'b1, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clkdiv);
        repeat (4) @(posedge clkdiv);
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor
    initial begin
        bit   prev_l;
        bit   prev_r;
        exp_t e;
        prev_l = 1'b0;
        prev_r = 1'b0;
        forever begin
            @(negedge clkdiv);
            if (reset) begin
                prev_l = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (left !== prev_l || right !== prev_r)
                    chk("lr_change_only_on_valid", byte_valid, 1);
                prev_l = left;
                prev_r = right;
                if (byte_valid || frame_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {byte_valid, frame_err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind_err", frame_err, e.err);
                        chk("event_kind_valid", byte_valid, !e.err);
                        if (!e.err) begin
                            chk("scan_code", scan_code, e.code);
                            chk("left", left, e.l);
                            chk("right", right, e.r);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clkdiv);
        #1;
        chk("rst_left", left, 0);
        chk("rst_right", right, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_scan_code", scan_code, 8'h00);
        reset = 1'b0;
        repeat (5) @(posedge clkdiv);

        // Left make
        send_byte(8'hE0, 0, 0);
        send_byte(8'h6B, 1, 0);
        drain("drain_left_make");

        // Right make, then left break
        send_byte(8'hE0, 1, 0);
        send_byte(8'h74, 1, 1);
        send_byte(8'hE0, 1, 1);
        send_byte(8'hF0, 1, 1);
        send_byte(8'h6B, 0, 1);
        drain("drain_both_then_break");

        // Typematic repeat holds right high
        send_byte(8'hE0, 0, 1);
        send_byte(8'h74, 0, 1);
        // Unprefixed codes do nothing and clear the flags
        send_byte(8'h6B, 0, 1);
        send_byte(8'h74, 0, 1);
        send_byte(8'hF0, 0, 1);
        send_byte(8'h74, 0, 1);
        drain("drain_unprefixed");

        // Bad stop bit
        expect_err();
        send_frame(8'h74, 1'b0, 1'b0);
        drain("drain_bad_stop");
        chk("bad_stop_left", left, 0);
        chk("bad_stop_right", right, 1);
        chk("bad_stop_scan", scan_code, 8'h74);

        // Right break
        send_byte(8'hE0, 0, 1);
        send_byte(8'hF0, 0, 1);
        send_byte(8'h74, 0, 0);
        drain("drain_right_break");

        // Timeout after 4 data bits
        expect_err();
        b = 8'h74;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
        repeat (TMO + 20) @(posedge clkdiv);
        drain("drain_timeout");
        send_byte(8'hE0, 0, 0);
        send_byte(8'h74, 0, 1);
        drain("drain_after_timeout");

        // Reset during 3rd data bit
        send_byte(8'hE0, 0, 1);
        send_byte(8'h6B, 1, 1);
        drain("drain_before_reset");
        b = 8'h74;
        ps2_bit(1'b0);
        ps2_bit(b[0]);
        ps2_bit(b[1]);
        ps2_data = b[2];
        repeat (3) @(posedge clkdiv);
        #1 reset = 1'b1;
        #1;
        chk("midreset_left", left, 0);
        chk("midreset_right", right, 0);
        chk("midreset_scan", scan_code, 8'h00);
        ps2_data = 1'b1;
        repeat (5) @(posedge clkdiv);
        reset = 1'b0;
        repeat (5) @(posedge clkdiv);
        send_byte(8'h74, 0, 0);
        drain("drain_after_reset");

`ifdef PS2_PARITY_CHECK_EN
        expect_err();
        send_frame(8'hE0, 1'b1, 1'b1);
        drain("drain_bad_parity");
        send_byte(8'h74, 0, 0);
        drain("drain_after_bad_parity");
`else
        expect_byte(8'hE0, 0, 0);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_byte(8'h74, 0, 1);
        drain("drain_parity_ignored");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/ps2_lr_decoder.md
PS2_LR_DECODER -- requirements
Module: ps2_lr_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, clkdiv cycles allowed between PS/2 falling edges inside a frame.
REQ-002 SHALL have port clkdiv  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous.
REQ-005 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous.
REQ-006 SHALL have port left  output  1  level, high while Left-arrow is held; drives the ball-position left input.
REQ-007 SHALL have port right  output  1  level, high while Right-arrow is held.
REQ-008 SHALL have port byte_valid  output  1  one-cycle pulse per accepted byte.
REQ-009 SHALL have port scan_code  output  8  last accepted byte.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers, then sample data on a detected synchronized ps2_clk 1->0 edge.
REQ-012 SHALL implement frame FSM IDLE->DATA->PARITY->STOP->IDLE: start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1.
REQ-013 IDLE: a falling edge with data=0 enters DATA; with data=1, stay in IDLE, no error.
REQ-014 DATA: 3-bit counter; after the 8th bit go to PARITY.
REQ-015 STOP: data=1 accepts the byte; data=0 pulses frame_err, discards the byte, returns to IDLE.
REQ-016 On acceptance, byte_valid SHALL pulse and scan_code SHALL update on the clkdiv edge after the stop-bit falling edge is detected.
REQ-017 Outside IDLE, if TIMEOUT_CYCLES cycles pass with no falling edge, SHALL pulse frame_err and return to IDLE; the counter resets on every falling edge.
REQ-018 Byte layer: 0xE0 sets ext flag; 0xF0 sets brk flag; flags persist until a non-prefix byte arrives.
REQ-019 Non-prefix byte with ext=1: 0x6B sets left<=~brk; 0x74 sets right<=~brk; any other code leaves left/right unchanged.
REQ-020 Every non-prefix byte SHALL clear ext and brk in the same cycle, whether used or not.
REQ-021 left and right are independent; both may be high together, and the consumer owns that conflict.
REQ-022 Repeated make codes (typematic) SHALL hold the level high with no glitch.
REQ-023 left and right SHALL change only in the byte_valid cycle.

Reset
REQ-024 reset SHALL force left=0, right=0, byte_valid=0, frame_err=0, scan_code=0x00, ext=0, brk=0, FSM=IDLE, bit and timeout counters=0, and synchronizers=1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release, decoding restarts only at the next start bit.

Configuration
REQ-026 Macro PS2_PARITY_CHECK_EN defined: a parity bit that makes the XOR of data and parity 0 (even) SHALL pulse frame_err at STOP and discard the byte.
REQ-027 Macro PS2_PARITY_CHECK_EN undefined: the parity bit is sampled but ignored, and every frame with a good stop bit is accepted.

Verification
REQ-028 Send E0,6B -> left=1, right=0; byte_valid pulses twice; scan_code=0x6B.
REQ-029 Send E0,6B,E0,74, then E0,F0,6B -> after the 4th byte left=1 and right=1; after the break sequence left=0 and right=1.
REQ-030 Send 6B without E0 prefix -> left stays 0, scan_code=0x6B, ext clear.
REQ-031 Frame 0x74 with stop bit 0 -> frame_err pulses once, no byte_valid, outputs unchanged.
REQ-032 Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES+1 cycles -> frame_err pulses; a following full E0,74 sets right=1.
REQ-033 Left held, then reset during the 3rd bit of the next frame -> left=0 immediately; with PS2_PARITY_CHECK_EN, a bad-parity 0xE0 -> frame_err and no byte_valid.
